// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - RV32I fetch stage with IF/ID register, skid buffer and redirect squash
// Optional macro FETCH_MISALIGN_CHECK_EN adds MisalignedFault and blocks fetches from misaligned redirect targets.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic        ImemReqValid,
  input  logic        ImemReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic        DecodeReady,
  output logic [31:0] Instruction,
  output logic [31:0] InstructionPC,
  output logic        InstructionValid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        MisalignedFault
`endif
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        drop_q, drop_d;
  logic        instr_valid_q, instr_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        fire;
  logic        out_free;
  logic        misaligned_redirect;

  assign ImemReqValid     = (state_q == ST_REQ);
  assign ImemAddr         = pc_q;
  assign Instruction      = instr_q;
  assign InstructionPC    = instr_pc_q;
  assign InstructionValid = instr_valid_q;

  assign fire     = ImemReqValid && ImemReady;
  assign out_free = !instr_valid_q || DecodeReady;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign misaligned_redirect = (RedirectTarget[1:0] != 2'b00);
  assign MisalignedFault     = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (RedirectValid) begin
      fault_d = misaligned_redirect;
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign misaligned_redirect = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;
    drop_d        = drop_q;

    if (instr_valid_q && DecodeReady) begin
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
    end

    if (RedirectValid) begin
      pc_d          = RedirectTarget;
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
      skid_valid_d  = 1'b0;
      // A faulted redirect parks in HOLD with an empty skid, so no fetch issues until the next redirect.
      if (misaligned_redirect) begin
        drop_d  = 1'b0;
        state_d = ST_HOLD;
      end else if (state_q == ST_WAIT && ImemRspValid) begin
        drop_d  = 1'b0;
        state_d = ST_REQ;
      end else if (state_q == ST_WAIT || fire) begin
        drop_d  = 1'b1;
        state_d = ST_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = ST_REQ;
      end
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (fire) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (ImemRspValid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else if (out_free) begin
              instr_d       = ImemRspData;
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
              pc_d          = pc_q + PC_STEP;
              state_d       = ST_REQ;
            end else begin
              skid_data_d  = ImemRspData;
              skid_pc_d    = pc_q;
              skid_valid_d = 1'b1;
              pc_d         = pc_q + PC_STEP;
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (skid_valid_q && out_free) begin
            instr_d       = skid_data_q;
            instr_pc_d    = skid_pc_q;
            instr_valid_d = 1'b1;
            skid_valid_d  = 1'b0;
            state_d       = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      skid_data_q   <= 32'h0;
      skid_pc_q     <= 32'h0;
      skid_valid_q  <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      skid_valid_q  <= skid_valid_d;
      drop_q        <= drop_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - bench for instruction_fetch_stage
// Directed vector table, hand sequences, then randomized run against an instruction-stream model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        ImemReqValid;
  logic        ImemReady = 1'b0;
  logic [31:0] ImemAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = 32'h0;
  logic        RedirectValid = 1'b0;
  logic [31:0] RedirectTarget = 32'h0;
  logic        DecodeReady = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] InstructionPC;
  logic        InstructionValid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        MisalignedFault;
`endif

  instruction_fetch_stage dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .ImemReqValid(ImemReqValid),
    .ImemReady(ImemReady),
    .ImemAddr(ImemAddr),
    .ImemRspValid(ImemRspValid),
    .ImemRspData(ImemRspData),
    .RedirectValid(RedirectValid),
    .RedirectTarget(RedirectTarget),
    .DecodeReady(DecodeReady),
    .Instruction(Instruction),
    .InstructionPC(InstructionPC),
    .InstructionValid(InstructionValid)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .MisalignedFault(MisalignedFault)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        redir;
    logic [31:0] tgt;
    logic        dr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] data,
                              input logic redir, input logic [31:0] tgt, input logic dr,
                              input logic e_req, input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.data = data; v.redir = redir; v.tgt = tgt; v.dr = dr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    ImemReady = 1'b0; ImemRspValid = 1'b0; ImemRspData = 32'h0;
    RedirectValid = 1'b0; RedirectTarget = 32'h0; DecodeReady = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ResetN = 1'b0;
    idle_inputs();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic req, input logic [31:0] addr,
                            input logic val, input logic [31:0] instr);
    chk({name, "_req"}, {31'h0, ImemReqValid}, {31'h0, req});
    chk({name, "_addr"}, ImemAddr, addr);
    chk({name, "_valid"}, {31'h0, InstructionValid}, {31'h0, val});
    chk({name, "_instr"}, Instruction, instr);
  endtask

  logic        pending;
  logic [31:0] paddr;
  int          pcnt;
  logic [31:0] exp_pc;
  int          consumed;
  logic        fire_now;

  initial begin
    // rdy rsp data redir tgt dr | req addr val instr pc
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h0,          0, NOP,            32'h0));
    vecs.push_back(mk(0, 1, 32'h0050_0093,  0, 32'h0,          1, 0, 32'h0,          0, NOP,            32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 1, 32'h4,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(0, 1, 32'h00a0_0113,  0, 32'h0,          0, 0, 32'h4,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h8,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h8,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h8,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h8,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 0, 32'h8,          1, 32'h0050_0093,  32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h8,          1, 32'h00a0_0113,  32'h4));
    vecs.push_back(mk(0, 1, 32'h0020_81b3,  0, 32'h0,          1, 0, 32'h8,          0, NOP,            32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'h100,        0, 1, 32'hC,          1, 32'h0020_81b3,  32'h8));
    vecs.push_back(mk(0, 1, 32'hDEAD_BEEF,  0, 32'h0,          1, 0, 32'h100,        0, NOP,            32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'h100,        0, NOP,            32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h100,        0, NOP,            32'h0));
    vecs.push_back(mk(0, 1, 32'h1111_1111,  0, 32'h0,          1, 0, 32'h100,        0, NOP,            32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hFFFF_FFFC,  1, 1, 32'h104,        1, 32'h1111_1111,  32'h100));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, NOP,            32'h0));
    vecs.push_back(mk(0, 1, 32'h2222_2222,  0, 32'h0,          1, 0, 32'hFFFF_FFFC,  0, NOP,            32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'h0,          1, 32'h2222_2222,  32'hFFFF_FFFC));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h0,          0, NOP,            32'h0));
    vecs.push_back(mk(0, 1, 32'h3333_3333,  1, 32'h40,         1, 0, 32'h0,          0, NOP,            32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h40,         0, NOP,            32'h0));
    vecs.push_back(mk(0, 1, 32'h4444_4444,  0, 32'h0,          1, 0, 32'h40,         0, NOP,            32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h44,         1, 32'h4444_4444,  32'h40));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val, vecs[i].e_instr);
      if (vecs[i].e_val) chk($sformatf("vec%0d_pc", i), InstructionPC, vecs[i].e_pc);
      ImemReady      = vecs[i].rdy;
      ImemRspValid   = vecs[i].rsp;
      ImemRspData    = vecs[i].data;
      RedirectValid  = vecs[i].redir;
      RedirectTarget = vecs[i].tgt;
      DecodeReady    = vecs[i].dr;
    end

    // Reset while a fetch is outstanding; the late response must be ignored.
    @(negedge Clock);
    ResetN = 1'b0; ImemReady = 1'b0; ImemRspValid = 1'b1; ImemRspData = 32'hBAD0_BAD0;
    RedirectValid = 1'b0;
    @(negedge Clock);
    expect_out("midreset", 1'b1, 32'h0, 1'b0, NOP);
    ResetN = 1'b1;
    @(negedge Clock);
    expect_out("stale_rsp", 1'b1, 32'h0, 1'b0, NOP);
    ImemRspValid = 1'b0;
    RedirectValid = 1'b1; RedirectTarget = 32'h102;
    @(negedge Clock);
    RedirectValid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      chk("fault_set", {31'h0, MisalignedFault}, 32'h1);
      chk("fault_noreq", {31'h0, ImemReqValid}, 32'h0);
      ImemReady = 1'b1;
      @(negedge Clock);
    end
    RedirectValid = 1'b1; RedirectTarget = 32'h200;
    @(negedge Clock);
    RedirectValid = 1'b0;
    chk("fault_clear", {31'h0, MisalignedFault}, 32'h0);
    expect_out("refetch", 1'b1, 32'h200, 1'b0, NOP);
    ImemReady = 1'b1;
    @(negedge Clock);
    ImemReady = 1'b0; ImemRspValid = 1'b1; ImemRspData = 32'h5555_5555;
    @(negedge Clock);
    ImemRspValid = 1'b0;
    expect_out("refetch_word", 1'b1, 32'h204, 1'b1, 32'h5555_5555);
    chk("refetch_pc", InstructionPC, 32'h200);
`else
    expect_out("misaligned_asis", 1'b1, 32'h102, 1'b0, NOP);
    ImemReady = 1'b1;
    @(negedge Clock);
    ImemReady = 1'b0; ImemRspValid = 1'b1; ImemRspData = 32'h5555_5555;
    @(negedge Clock);
    ImemRspValid = 1'b0;
    expect_out("misaligned_word", 1'b1, 32'h106, 1'b1, 32'h5555_5555);
    chk("misaligned_pc", InstructionPC, 32'h102);
`endif

    // Randomized run: delivered words must form the stream target, target+4, ... after each redirect.
    do_reset();
    pending = 1'b0; paddr = 32'h0; pcnt = 0; exp_pc = 32'h0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      if (!InstructionValid) chk("nop_when_invalid", Instruction, NOP);
      DecodeReady    = ($urandom_range(0, 3) != 0);
      ImemReady      = ($urandom_range(0, 2) != 0);
      RedirectValid  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: RedirectTarget = $urandom & 32'h0000_0FFC;
        1: RedirectTarget = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: RedirectTarget = $urandom & 32'hFFFF_FFFC;
      endcase
`ifndef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(0, 3) == 0) RedirectTarget[1:0] = 2'($urandom_range(1, 3));
`endif
      ImemRspValid = pending && (pcnt == 0);
      ImemRspData  = ImemRspValid ? mem_word(paddr) : $urandom;
      #1;
      if (InstructionValid && DecodeReady) begin
        chk("stream_pc", InstructionPC, exp_pc);
        chk("stream_instr", Instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (RedirectValid) exp_pc = RedirectTarget;
      fire_now = ImemReqValid && ImemReady;
      if (ImemRspValid) pending = 1'b0;
      else if (pending) pcnt--;
      if (fire_now) begin
        chk("one_outstanding", {31'h0, pending}, 32'h0);
        pending = 1'b1;
        paddr   = ImemAddr;
        pcnt    = $urandom_range(0, 2);
      end
    end
    chk("progress", {31'h0, (consumed > 200)}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
